if_id_buffer: RTL

Decoupling buffer between the instruction-fetch stage and the decode stage. Captures each fetched instruction word with its PC+4, holds up to DEPTH entries in order, and presents them to decode through a valid/ready handshake. Back-pressures fetch through a stall-style ready signal. Discards all held entries on a flush from branch, jump or jr redirection.

---
 rtl/mips_pkg.sv | 13 +
 rtl/if_id_ram.sv | 25 ++
 rtl/if_id_buffer.sv | 117 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data width, NOP encoding and the IF/ID entry payload.
package mips_pkg;

    localparam int unsigned REG_LEN = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [REG_LEN-1:0] inst;
        logic [REG_LEN-1:0] pc_plus4;
    } if_id_entry_t;

endpackage : mips_pkg

// File: rtl/if_id_ram.sv
// IF/ID entry storage: one synchronous write port, one combinational read port, no reset.
module if_id_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned W     = 64
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : if_id_ram

// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling FIFO with valid/ready handshakes and redirect flush.
// Optional same-cycle forwarding on an empty buffer when IF_ID_BUFFER_BYPASS_EN is defined.
module if_id_buffer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [REG_LEN-1:0]         in_inst,
    input  logic [REG_LEN-1:0]         in_pc_plus4,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [REG_LEN-1:0]         out_inst,
    output logic [REG_LEN-1:0]         out_pc_plus4,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = $bits(if_id_entry_t);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic         buf_valid_c;
    logic         bypass_c;
    logic         push_c;
    logic         pop_c;
    if_id_entry_t wr_entry_c;
    if_id_entry_t rd_entry_c;

    assign buf_valid_c = (count_q != '0);

`ifdef IF_ID_BUFFER_BYPASS_EN
    assign bypass_c = !buf_valid_c && in_valid && !flush;
`else
    assign bypass_c = 1'b0;
`endif

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = buf_valid_c || bypass_c;
    assign count     = count_q;

    // A forwarded word taken by decode in the same cycle never occupies an entry.
    assign pop_c  = buf_valid_c && out_ready;
    assign push_c = in_valid && in_ready && !flush && !(bypass_c && out_ready);

    assign wr_entry_c = '{inst: in_inst, pc_plus4: in_pc_plus4};

    if_id_ram #(
        .DEPTH (DEPTH),
        .AW    (PTR_W),
        .W     (ENT_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry_c)
    );

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Decode sees a NOP whenever nothing valid is presented.
    always_comb begin
        out_inst     = REG_LEN'(NOP_INST);
        out_pc_plus4 = '0;
        if (bypass_c) begin
            out_inst     = in_inst;
            out_pc_plus4 = in_pc_plus4;
        end else if (buf_valid_c) begin
            out_inst     = rd_entry_c.inst;
            out_pc_plus4 = rd_entry_c.pc_plus4;
        end
    end

endmodule : if_id_buffer
